frame_stream_decoder: RTL and testbench
=======================================

// Module: frame_stream_decoder
// PURPOSE
// - Consumer end of the 17-bit pixel queue, the counterpart of the pattern/camera stream writers.
// - Word format: bit16=1 is a control word; low 16 bits are 0x0000 frame start, 0x0001 row start,
//   0xFFFF frame end. Other control words are reserved. bit16=0 is a pixel: RGB565 in bits[15:0].
// - Pops words from a synchronous FIFO and tags each pixel with x/y coordinates.
// - Emits a valid/ready beat stream to the framebuffer writer.
// PARAMETERS
// - FRAME_WIDTH   480  pixels per row; x range 0..FRAME_WIDTH-1
// - FRAME_HEIGHT  272  rows per frame; y range 0..FRAME_HEIGHT-1
// PORTS
// - clk          in   1   clock
// - reset_n      in   1   asynchronous, active-low reset
// - queue_empty  in   1   FIFO empty
// - queue_rd_en  out  1   FIFO pop; the FIFO returns queue_data one cycle later
// - queue_data   in   17  FIFO read word
// - out_valid    out  1   output beat valid
// - out_ready    in   1   downstream accept; a beat transfers when out_valid&&out_ready
// - out_data     out  16  pixel colour (0 on frame-end beat)
// - out_x        out  11  pixel column
// - out_y        out  11  pixel row
// - out_sof      out  1   beat is pixel (0,0) of a frame
// - out_eol      out  1   beat is the last pixel of a row (x==FRAME_WIDTH-1)
// - out_eof      out  1   frame-end beat; carries no pixel
// - protocol_err out  1   1-cycle pulse per protocol violation
// - err_count    out  16  saturating count of violations
// BEHAVIOUR
// - Reset values: queue_rd_en=0, out_valid=0, all out_* fields=0, protocol_err=0, err_count=0.
//   Reset also sets state=WAIT_FRAME, x=y=0, buffer empty, no read in flight.
// - Reset mid-operation: any in-flight FIFO word is discarded; it is never forwarded.
// - Output buffer: 2-entry skid buffer; out_* are driven from the head entry and stay stable
//   while out_valid&&!out_ready.
// - Read issue: queue_rd_en = !queue_empty && (occupancy + inflight - pop_this_cycle) < 2.
//   This gives 1 word/clk sustained when out_ready=1.
// - Latency: FIFO word popped at cycle t reaches the parser at t+1; its beat is visible at t+2.
// - States:
//   - WAIT_FRAME: discard all words until frame start. Pixels here are a violation.
//   - WAIT_ROW: row start -> PIXELS with x=0.
//     Frame end -> push eof beat, go to WAIT_FRAME.
//     Pixel -> violation, dropped.
//   - PIXELS: pixel -> push beat (x,y); x++.
//     At x==FRAME_WIDTH-1 set out_eol, go to WAIT_ROW, y++.
//     Row start -> stay in PIXELS, x=0. If x!=0 (short row): violation, y++.
//     If x==0: duplicate marker, no-op.
//     Frame end -> push eof beat. If x!=0 (short row): violation. Go to WAIT_FRAME.
//   - Frame start in any state: resync to WAIT_ROW with x=y=0.
//     Mid-frame (not WAIT_FRAME): also a violation.
// - Row start when y==FRAME_HEIGHT: violation; drop all pixels until frame end.
//   Frame end with y<FRAME_HEIGHT is accepted: eof beat plus a violation.
// - Reserved control words: ignored and counted as violations.
// - out_sof=1 only on the beat with x==0,y==0. out_eof beats: out_x=out_y=0.
// - A parser push never occurs when the buffer is full, guaranteed by the read-issue rule.
// - Simultaneous violation and push in one cycle: both occur. err_count saturates at 0xFFFF.
// CONFIGURATION
// - STREAM_ERROR_CHECK_EN defined:
//   - full checking as above; protocol_err and err_count are live;
//   - overlong rows are dropped: a pixel in WAIT_ROW is dropped and counted.
// - STREAM_ERROR_CHECK_EN undefined:
//   - protocol_err and err_count are tied to 0;
//   - no row bounds checking: a pixel in WAIT_ROW is forwarded with x continuing (11-bit wrap),
//     y unchanged;
//   - the y==FRAME_HEIGHT overflow check is removed;
//   - pixels in WAIT_FRAME are still dropped.
// TESTING
// - Setup: W=4, H=2, out_ready=1.
// - Nominal frame: 10000,10001,p0..p3,10001,p4..p7,1FFFF -> 8 beats with (x,y) = (0,0)..(3,1),
//   then an eof beat. sof on p0; eol on p3 and p7; protocol_err never asserted.
// - Backpressure: same stream, out_ready toggling 1010...
//   -> identical beat order and values; out_* stable while stalled; no word lost or duplicated.
// - Duplicate row start: 10000,10001,10001,p0..p3,... -> output same as nominal; err_count=0.
// - Short row: 10000,10001,p0,p1,10001,p2..p5,1FFFF
//   -> p0,p1 at y=0; p2..p5 at y=1, x=0..3; 1 error pulse; err_count=1.
// - Garbage and resync: p9 before any frame start -> dropped, err_count=1.
//   Then 10000 mid-row -> x=y=0 restart, err_count=2.
// - Async reset while a read is in flight -> all outputs 0 next cycle.
//   The late FIFO word is never emitted; the following frame decodes normally.

Source files
------------

// File: rtl/frame_stream_decoder.sv
// Pops 17-bit control/pixel words from a synchronous FIFO, tags pixels with x/y and emits beats via a 2-entry skid buffer.
// Optional checking build: define STREAM_ERROR_CHECK_EN for violation reporting and row/frame bounds checks.
module frame_stream_decoder #(
    parameter int FRAME_WIDTH  = 480,
    parameter int FRAME_HEIGHT = 272
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        queue_empty,
    output logic        queue_rd_en,
    input  logic [16:0] queue_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [10:0] out_x,
    output logic [10:0] out_y,
    output logic        out_sof,
    output logic        out_eol,
    output logic        out_eof,
    output logic        protocol_err,
    output logic [15:0] err_count
);
`ifdef STREAM_ERROR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam logic [10:0] X_LAST = 11'(FRAME_WIDTH - 1);
    localparam logic [10:0] Y_END  = 11'(FRAME_HEIGHT);

    typedef struct packed {
        logic [15:0] data;
        logic [10:0] x;
        logic [10:0] y;
        logic        sof;
        logic        eol;
        logic        eof;
    } beat_t;

    typedef enum logic [1:0] {WAIT_FRAME, WAIT_ROW, PIXELS, DROP} state_t;

    state_t      state, state_n;
    logic [10:0] x, x_n, y, y_n;
    logic        inflight, rd_ok, push, pop, viol;
    logic [1:0]  occ;
    logic [2:0]  load;
    beat_t       head, tail, push_beat;

    // Reads are held off for one cycle after reset so queue_rd_en is 0 in reset.
    assign out_valid   = (occ != 2'd0);
    assign pop         = out_valid && out_ready;
    assign load        = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign queue_rd_en = rd_ok && !queue_empty && (load < 3'd2);

    assign out_data = head.data;
    assign out_x    = head.x;
    assign out_y    = head.y;
    assign out_sof  = head.sof;
    assign out_eol  = head.eol;
    assign out_eof  = head.eof;

    always_comb begin
        state_n        = state;
        x_n            = x;
        y_n            = y;
        push           = 1'b0;
        viol           = 1'b0;
        push_beat      = '0;
        push_beat.data = queue_data[15:0];
        push_beat.x    = x;
        push_beat.y    = y;
        push_beat.sof  = (x == 11'd0) && (y == 11'd0);
        push_beat.eol  = (x == X_LAST);
        if (inflight) begin
            if (!queue_data[16]) begin
                case (state)
                    WAIT_FRAME: viol = 1'b1;
                    WAIT_ROW: begin
`ifdef STREAM_ERROR_CHECK_EN
                        viol = 1'b1;
`else
                        push = 1'b1;
                        x_n  = x + 11'd1;
`endif
                    end
                    PIXELS: begin
                        push = 1'b1;
                        x_n  = x + 11'd1;
                        if (x == X_LAST) begin
                            state_n = WAIT_ROW;
                            y_n     = y + 11'd1;
                        end
                    end
                    default: ;
                endcase
            end else begin
                case (queue_data[15:0])
                    16'h0000: begin
                        viol    = (state != WAIT_FRAME);
                        state_n = WAIT_ROW;
                        x_n     = 11'd0;
                        y_n     = 11'd0;
                    end
                    16'h0001: begin
                        if (state == WAIT_ROW) begin
                            if (CHK && y == Y_END) begin
                                viol    = 1'b1;
                                state_n = DROP;
                            end else begin
                                state_n = PIXELS;
                                x_n     = 11'd0;
                            end
                        end else if (state == PIXELS && x != 11'd0) begin
                            // Short row: close it out and start the next one.
                            viol = 1'b1;
                            x_n  = 11'd0;
                            y_n  = y + 11'd1;
                            if (CHK && (y + 11'd1) == Y_END) state_n = DROP;
                        end
                    end
                    16'hFFFF: begin
                        if (state != WAIT_FRAME) begin
                            push          = 1'b1;
                            push_beat     = '0;
                            push_beat.eof = 1'b1;
                            viol          = (state == PIXELS && x != 11'd0) || (y < Y_END);
                            state_n       = WAIT_FRAME;
                        end
                    end
                    default: viol = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= WAIT_FRAME;
            x            <= '0;
            y            <= '0;
            inflight     <= 1'b0;
            rd_ok        <= 1'b0;
            occ          <= '0;
            head         <= '0;
            tail         <= '0;
            protocol_err <= 1'b0;
            err_count    <= '0;
        end else begin
            state        <= state_n;
            x            <= x_n;
            y            <= y_n;
            inflight     <= queue_rd_en;
            rd_ok        <= 1'b1;
            protocol_err <= CHK && viol;
            if (CHK && viol && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            // Head only changes on pop or when loading an empty buffer, keeping out_* stable under stall.
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= push_beat;
                    else             tail <= push_beat;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) head <= push_beat;
                    else begin
                        head <= tail;
                        tail <= push_beat;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_stream_decoder.sv
// Scoreboard bench for frame_stream_decoder with W=4, H=2; expectations follow STREAM_ERROR_CHECK_EN.
module tb_frame_stream_decoder;
`ifdef STREAM_ERROR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int W = 4;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        queue_empty = 1'b1;
    logic        queue_rd_en;
    logic [16:0] queue_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [10:0] out_x, out_y;
    logic        out_sof, out_eol, out_eof;
    logic        protocol_err;
    logic [15:0] err_count;

    frame_stream_decoder #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
        .clk(clk), .reset_n(reset_n), .queue_empty(queue_empty), .queue_rd_en(queue_rd_en),
        .queue_data(queue_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_x(out_x), .out_y(out_y), .out_sof(out_sof),
        .out_eol(out_eol), .out_eof(out_eof), .protocol_err(protocol_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    logic [16:0] fq[$];
    logic [40:0] sb[$];
    bit          bp = 1'b0;
    int          n_chk = 0, n_fail = 0, pulses = 0;
    bit          mon_en = 1'b0, stalled = 1'b0;
    logic [40:0] held;

    // FIFO model: word popped on a rd_en edge appears on queue_data after that edge.
    always @(posedge clk) begin
        if (queue_rd_en && fq.size() > 0) queue_data <= fq.pop_front();
        queue_empty <= (fq.size() == 0);
    end

    always @(posedge clk) out_ready <= bp ? ~out_ready : 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [40:0] pix(input int d, input int x, input int y);
        return {16'(d), 11'(x), 11'(y), (x == 0 && y == 0), (x == W - 1), 1'b0};
    endfunction

    function automatic logic [40:0] eofb();
        return {16'h0, 11'h0, 11'h0, 3'b001};
    endfunction

    function automatic logic [40:0] cur_beat();
        return {out_data, out_x, out_y, out_sof, out_eol, out_eof};
    endfunction

    task automatic tick();
        @(negedge clk);
        if (mon_en) begin
            if (protocol_err) pulses++;
            if (stalled) chk("stall_stable", cur_beat(), held);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("extra_beat", cur_beat(), 41'h0);
                else chk("beat", cur_beat(), sb.pop_front());
            end
        end
        stalled = out_valid && !out_ready;
        held    = cur_beat();
    endtask

    task automatic do_reset();
        mon_en  = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        fq.delete();
        sb.delete();
        reset_n = 1'b1;
        tick();
        pulses  = 0;
        stalled = 1'b0;
        mon_en  = 1'b1;
    endtask

    task automatic px(input int d);
        fq.push_back({1'b0, 16'(d)});
    endtask

    task automatic ctl(input logic [15:0] c);
        fq.push_back({1'b1, c});
    endtask

    // Two full rows of pixels base..base+7; the caller adds frame markers.
    task automatic rows(input int base);
        for (int r = 0; r < H; r++) begin
            ctl(16'h0001);
            for (int c = 0; c < W; c++) begin
                px(base + r * W + c);
                sb.push_back(pix(base + r * W + c, c, r));
            end
        end
    endtask

    task automatic finish_test(input string name, input int exp_err);
        int idle = 0;
        for (int i = 0; i < 400 && idle < 4; i++) begin
            tick();
            if (fq.size() == 0 && sb.size() == 0 && !out_valid) idle++;
            else idle = 0;
        end
        chk({name, "_sb_left"}, sb.size(), 0);
        chk({name, "_fifo_left"}, fq.size(), 0);
        chk({name, "_err_pulses"}, pulses, CHK ? exp_err : 0);
        chk({name, "_err_count"}, err_count, CHK ? exp_err : 0);
    endtask

    initial begin
        bit seen;
        // Reset values, with a word waiting in the FIFO to show reads are held off.
        reset_n = 1'b0;
        px(16'h5555);
        tick();
        tick();
        chk("rst_rd_en", queue_rd_en, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_beat", cur_beat(), 0);
        chk("rst_perr", protocol_err, 0);
        chk("rst_errcnt", err_count, 0);

        do_reset();
        ctl(16'h0000); rows(16'hA000); ctl(16'hFFFF); sb.push_back(eofb());
        finish_test("nominal", 0);

        do_reset();
        bp = 1'b1;
        ctl(16'h0000); rows(16'hB000); ctl(16'hFFFF); sb.push_back(eofb());
        finish_test("backpressure", 0);
        bp = 1'b0;

        do_reset();
        ctl(16'h0000); ctl(16'h0001); rows(16'hC000); ctl(16'hFFFF); sb.push_back(eofb());
        finish_test("dup_row", 0);

        do_reset();
        ctl(16'h0000); ctl(16'h0001);
        px(16'hD000); sb.push_back(pix(16'hD000, 0, 0));
        px(16'hD001); sb.push_back(pix(16'hD001, 1, 0));
        ctl(16'h0001);
        for (int c = 0; c < W; c++) begin
            px(16'hD010 + c);
            sb.push_back(pix(16'hD010 + c, c, 1));
        end
        ctl(16'hFFFF); sb.push_back(eofb());
        finish_test("short_row", 1);

        do_reset();
        px(16'h9999);
        ctl(16'h0000); ctl(16'h0001);
        px(16'hE0A0); sb.push_back(pix(16'hE0A0, 0, 0));
        px(16'hE0A1); sb.push_back(pix(16'hE0A1, 1, 0));
        ctl(16'h0000); rows(16'hE000); ctl(16'hFFFF); sb.push_back(eofb());
        finish_test("garbage_resync", 2);

        do_reset();
        ctl(16'h0000); ctl(16'h0001);
        for (int c = 0; c < W; c++) begin
            px(16'hF000 + c);
            sb.push_back(pix(16'hF000 + c, c, 0));
        end
        px(16'hF0FF);
        if (!CHK) sb.push_back({16'hF0FF, 11'd4, 11'd1, 3'b000});
        ctl(16'h0001);
        for (int c = 0; c < W; c++) begin
            px(16'hF010 + c);
            sb.push_back(pix(16'hF010 + c, c, 1));
        end
        ctl(16'hFFFF); sb.push_back(eofb());
        finish_test("overlong_row", 1);

        do_reset();
        ctl(16'h0000); rows(16'h1000); ctl(16'h0001); px(16'h1FFF);
        if (!CHK) sb.push_back({16'h1FFF, 11'd0, 11'd2, 3'b000});
        ctl(16'hFFFF); sb.push_back(eofb());
        finish_test("row_overflow", 1);

        // Reset lands while a frame-start word is in flight from the FIFO.
        do_reset();
        ctl(16'h0000);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = queue_rd_en;
        end
        chk("midrst_read_seen", seen, 1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("midrst_rd_en", queue_rd_en, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_beat", cur_beat(), 0);
        chk("midrst_errcnt", err_count, 0);
        tick();
        fq.delete();
        sb.delete();
        reset_n = 1'b1;
        tick();
        pulses = 0;
        stalled = 1'b0;
        mon_en = 1'b1;
        ctl(16'h0001); px(16'h7777); ctl(16'hFFFF);
        ctl(16'h0000); rows(16'h2000); ctl(16'hFFFF); sb.push_back(eofb());
        finish_test("after_midrst", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
